// File: rtl/sklansky_pipe_addsub_if.sv
// Operand/result bus for sklansky_pipe_addsub.
// The master side drives operands and out_ready; the slave side (the adder)
// drives in_ready and the result fields.
interface sklansky_pipe_addsub_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/sklansky_pipe_addsub.sv
// Pipelined Sklansky parallel-prefix adder/subtractor.
// Stage S0 forms propagate/generate (carry-in folded into bit 0), stages
// S1..S_LVL each register one Sklansky prefix level, and the output register
// resolves sum/cout/ovf. All stages advance together; a stalled output
// freezes the whole pipe.
// Optional macro SKLANSKY_ZERO_FLAG_EN: when defined, a registered zero flag
// (sum == 0) is produced alongside the sum; otherwise zero is tied to 0.
module sklansky_pipe_addsub #(
  parameter int N = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  sklansky_pipe_addsub_if.slave bus
);
  localparam int LVL = $clog2(N);

  // Global advance and input acceptance
  logic adv;
  logic accept;

  // S0 combinational inputs
  logic [N-1:0] b_eff;
  logic         c0_in;
  logic [N-1:0] p_in;
  logic [N-1:0] g_in;

  // Next values per stage: index 0 is S0, index j is the output of level j
  logic [LVL:0][N-1:0]   nxt_g;
  logic [LVL-1:0][N-1:0] nxt_p;

  // Stage registers
  logic [LVL:0]          v_q, v_d;
  logic [LVL:0][N-1:0]   g_q, g_d;
  logic [LVL-1:0][N-1:0] p_q, p_d;
  logic [LVL:0][N-1:0]   po_q, po_d;
  logic [LVL:0]          c0_q, c0_d;
  logic [LVL:0]          sign_a_q, sign_a_d;
  logic [LVL:0]          sign_b_q, sign_b_d;

  // Output registers
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;
  logic         ovf_q, ovf_d;

  // Final-stage combinational results
  logic [N-1:0] carry_vec;
  logic [N-1:0] sum_fin;
  logic         cout_fin;
  logic         ovf_fin;

`ifdef SKLANSKY_ZERO_FLAG_EN
  logic zero_q, zero_d;
  logic zero_fin;
`endif

  assign adv    = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && adv;

  // S0: invert B for subtract, form P/G and fold the carry-in into bit 0
  always_comb begin
    b_eff    = bus.sub ? ~bus.b : bus.b;
    c0_in    = bus.sub | bus.cin;
    p_in     = bus.a ^ b_eff;
    g_in     = bus.a & b_eff;
    g_in[0]  = g_in[0] | (p_in[0] & c0_in);
  end

  assign nxt_g[0] = g_in;
  assign nxt_p[0] = p_in;

  // Sklansky levels: upper half of each 2^j group combines with the top bit
  // of the lower half; the group propagate of the last level is never needed.
  for (genvar j = 1; j <= LVL; j++) begin : g_lvl
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i >> (j - 1)) % 2) == 1) begin : g_comb
        localparam int K = ((i >> (j - 1)) << (j - 1)) - 1;
        assign nxt_g[j][i] = g_q[j-1][i] | (p_q[j-1][i] & g_q[j-1][K]);
        if (j < LVL) begin : g_p
          assign nxt_p[j][i] = p_q[j-1][i] & p_q[j-1][K];
        end
      end else begin : g_pass
        assign nxt_g[j][i] = g_q[j-1][i];
        if (j < LVL) begin : g_p
          assign nxt_p[j][i] = p_q[j-1][i];
        end
      end
    end
  end

  // Final stage: carries from the prefix generates, then sum and flags.
  // With equal operand signs, overflow is a result sign differing from them,
  // which is the same as C[N] ^ C[N-1].
  always_comb begin
    carry_vec = {g_q[LVL][N-2:0], c0_q[LVL]};
    sum_fin   = po_q[LVL] ^ carry_vec;
    cout_fin  = g_q[LVL][N-1];
    ovf_fin   = (sign_a_q[LVL] == sign_b_q[LVL]) && (sum_fin[N-1] != sign_a_q[LVL]);
  end

`ifdef SKLANSKY_ZERO_FLAG_EN
  // Zero reduction lives in the final stage so it adds no latency
  always_comb begin
    zero_fin = ~|sum_fin;
  end
`endif

  // Next-state: every stage shifts on adv and holds otherwise; the output
  // result fields only load when a valid beat arrives so they stay put.
  always_comb begin
    v_d         = v_q;
    g_d         = g_q;
    p_d         = p_q;
    po_d        = po_q;
    c0_d        = c0_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
`ifdef SKLANSKY_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    if (adv) begin
      v_d         = {v_q[LVL-1:0], accept};
      g_d         = nxt_g;
      p_d         = nxt_p;
      po_d        = {po_q[LVL-1:0], p_in};
      c0_d        = {c0_q[LVL-1:0], c0_in};
      sign_a_d    = {sign_a_q[LVL-1:0], bus.a[N-1]};
      sign_b_d    = {sign_b_q[LVL-1:0], b_eff[N-1]};
      out_valid_d = v_q[LVL];
      if (v_q[LVL]) begin
        sum_d  = sum_fin;
        cout_d = cout_fin;
        ovf_d  = ovf_fin;
`ifdef SKLANSKY_ZERO_FLAG_EN
        zero_d = zero_fin;
`endif
      end
    end
  end

  // State registers with asynchronous clear of all beats and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      g_q         <= '0;
      p_q         <= '0;
      po_q        <= '0;
      c0_q        <= '0;
      sign_a_q    <= '0;
      sign_b_q    <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef SKLANSKY_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      v_q         <= v_d;
      g_q         <= g_d;
      p_q         <= p_d;
      po_q        <= po_d;
      c0_q        <= c0_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
`ifdef SKLANSKY_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
`ifdef SKLANSKY_ZERO_FLAG_EN
  assign bus.zero      = zero_q;
`else
  assign bus.zero      = 1'b0;
`endif

endmodule

// File: tb/tb_sklansky_pipe_addsub.sv
// Testbench for sklansky_pipe_addsub: three instances (N=16, 8, 13) driven in
// lockstep with truncated copies of the same operands, each compared every
// cycle against an arithmetic reference model of its pipeline.
// Honours SKLANSKY_ZERO_FLAG_EN for the zero-flag expectation.
module tb_sklansky_pipe_addsub;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sklansky_pipe_addsub_if #(.N(16)) if16 ();
  sklansky_pipe_addsub_if #(.N(8))  if8  ();
  sklansky_pipe_addsub_if #(.N(13)) if13 ();

  sklansky_pipe_addsub #(.N(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  sklansky_pipe_addsub #(.N(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  sklansky_pipe_addsub #(.N(13)) u_dut13 (.clk(clk), .rst_n(rst_n), .bus(if13));

  typedef struct packed {
    logic        v;
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } beat_t;

  // Model pipeline per instance: slot lat-1 is what the output should show
  beat_t mdl [3][8];

  int errors = 0;
  int checks = 0;

  logic        cur_v, cur_cin, cur_sub, cur_rdy;
  logic [15:0] cur_a, cur_b;

  function automatic int width_of(int k);
    case (k)
      0:       return 16;
      1:       return 8;
      default: return 13;
    endcase
  endfunction

  function automatic int lat_of(int k);
    case (k)
      0:       return 6;
      1:       return 5;
      default: return 6;
    endcase
  endfunction

  // Expected result from plain unsigned/signed arithmetic on an n-bit word
  function automatic beat_t ref_beat(int n, logic [15:0] a, logic [15:0] b,
                                     logic cin, logic sub);
    beat_t  r;
    longint mask, half, ua, ub, sa, sb, full, res;
    mask = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    if (sub) begin
      full = ua - ub;
      res  = sa - sb;
      r.c  = (ua >= ub);
    end else begin
      full = ua + ub + longint'(cin);
      res  = sa + sb + longint'(cin);
      r.c  = (full > mask);
    end
    r.v = 1'b1;
    r.s = 16'(full & mask);
    r.o = (res < -half) || (res >= half);
`ifdef SKLANSKY_ZERO_FLAG_EN
    r.z = (r.s == 16'h0);
`else
    r.z = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_obs(int k, output logic v, output logic r, output logic [15:0] s,
                         output logic c, output logic o, output logic z);
    case (k)
      0: begin
        v = if16.out_valid; r = if16.in_ready; s = if16.sum;
        c = if16.cout; o = if16.ovf; z = if16.zero;
      end
      1: begin
        v = if8.out_valid; r = if8.in_ready; s = {8'h0, if8.sum};
        c = if8.cout; o = if8.ovf; z = if8.zero;
      end
      default: begin
        v = if13.out_valid; r = if13.in_ready; s = {3'h0, if13.sum};
        c = if13.cout; o = if13.ovf; z = if13.zero;
      end
    endcase
  endtask

  task automatic applyStimulus(logic v, logic [15:0] a, logic [15:0] b,
                               logic cin, logic sub, logic rdy);
    cur_v = v; cur_a = a; cur_b = b; cur_cin = cin; cur_sub = sub; cur_rdy = rdy;
    if16.in_valid = v; if16.a = a;       if16.b = b;       if16.cin = cin; if16.sub = sub; if16.out_ready = rdy;
    if8.in_valid  = v; if8.a  = a[7:0];  if8.b  = b[7:0];  if8.cin  = cin; if8.sub  = sub; if8.out_ready  = rdy;
    if13.in_valid = v; if13.a = a[12:0]; if13.b = b[12:0]; if13.cin = cin; if13.sub = sub; if13.out_ready = rdy;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++)
        mdl[k][i] = '0;
  endtask

  task automatic checkOutput();
    logic v, r, c, o, z;
    logic [15:0] s;
    beat_t e;
    for (int k = 0; k < 3; k++) begin
      get_obs(k, v, r, s, c, o, z);
      e = mdl[k][lat_of(k) - 1];
      check($sformatf("n%0d out_valid", width_of(k)), 32'(v), 32'(e.v));
      if (e.v) begin
        check($sformatf("n%0d sum", width_of(k)),  32'(s), 32'(e.s));
        check($sformatf("n%0d cout", width_of(k)), 32'(c), 32'(e.c));
        check($sformatf("n%0d ovf", width_of(k)),  32'(o), 32'(e.o));
        check($sformatf("n%0d zero", width_of(k)), 32'(z), 32'(e.z));
      end
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check after
  task automatic tick();
    beat_t nxt [3][8];
    logic  v, r, c, o, z, adv;
    logic [15:0] s;
    int lat;
    @(negedge clk);
    nxt = mdl;
    for (int k = 0; k < 3; k++) begin
      lat = lat_of(k);
      adv = !mdl[k][lat-1].v || cur_rdy;
      get_obs(k, v, r, s, c, o, z);
      check($sformatf("n%0d in_ready", width_of(k)), 32'(r), 32'(adv));
      if (adv) begin
        for (int i = lat - 1; i > 0; i--) nxt[k][i] = mdl[k][i-1];
        nxt[k][0] = cur_v ? ref_beat(width_of(k), cur_a, cur_b, cur_cin, cur_sub) : '0;
      end
    end
    @(posedge clk);
    #1;
    mdl = nxt;
    checkOutput();
  endtask

  // Single beat into an empty pipe, then spec-literal values 6 cycles later
  task automatic directed(string tag, logic [15:0] a, logic [15:0] b, logic cin, logic sub,
                          logic [15:0] es, logic ec, logic eo, logic ez_on);
    logic ez;
`ifdef SKLANSKY_ZERO_FLAG_EN
    ez = ez_on;
`else
    ez = 1'b0;
`endif
    applyStimulus(1'b1, a, b, cin, sub, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    check({tag, " valid"}, 32'(if16.out_valid), 32'd1);
    check({tag, " sum"},   32'(if16.sum),       32'(es));
    check({tag, " cout"},  32'(if16.cout),      32'(ec));
    check({tag, " ovf"},   32'(if16.ovf),       32'(eo));
    check({tag, " zero"},  32'(if16.zero),      32'(ez));
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    clear_model();
    #12;
    check("rst out_valid", 32'(if16.out_valid), 32'd0);
    check("rst in_ready",  32'(if16.in_ready),  32'd1);
    check("rst sum",       32'(if16.sum),       32'd0);
    check("rst cout",      32'(if16.cout),      32'd0);
    check("rst ovf",       32'(if16.ovf),       32'd0);
    check("rst zero",      32'(if16.zero),      32'd0);
    check("rst n8 valid",  32'(if8.out_valid),  32'd0);
    check("rst n13 valid", 32'(if13.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    directed("add1234", 16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0, 1'b0);
    directed("ripple",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("sub_neg", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Back-to-back streaming
    $display("[TB] streaming 20 beats");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (8) tick();

    // Backpressure: five stalled cycles mid-stream
    $display("[TB] backpressure");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    (i >= 8 && i < 13) ? 1'b0 : 1'b1);
      tick();
      if (i >= 8 && i < 13) check("stall in_ready", 32'(if16.in_ready), 32'd0);
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (8) tick();

    // Asynchronous reset with beats in flight
    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("arst n16 valid",    32'(if16.out_valid), 32'd0);
    check("arst n8 valid",     32'(if8.out_valid),  32'd0);
    check("arst n13 valid",    32'(if13.out_valid), 32'd0);
    check("arst n16 in_ready", 32'(if16.in_ready),  32'd1);
    clear_model();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) tick();

    // Random traffic with random backpressure on all widths
    $display("[TB] random sweep");
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(3) != 0), 16'($urandom), 16'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom_range(3) != 0));
      tick();
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
